// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding and the
// flow-control field values carried by each instruction.
package prog_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    WAIT_STEP = 3'd2,
    STEP_EXEC = 3'd3,
    HALT      = 3'd4
  } seq_state_e;

  localparam logic [1:0] BR_NEXT = 2'b00;
  localparam logic [1:0] BR_JUMP = 2'b01;
  localparam logic [1:0] BR_BZ   = 2'b10;
  localparam logic [1:0] BR_HALT = 2'b11;

endpackage

// File: rtl/prog_sequencer_edge_detect.sv
// Registered rising-edge detector: rise pulses for one cycle, one clock after
// din goes from low to high, no matter how long din then stays high.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      din_q <= din;
      rise  <= din & ~din_q;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: generates the instruction-ROM address and gates the
// register-file write strobe to cycles where an instruction executes.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int AW = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic [1:0]    br_op,
  input  logic [AW-1:0] br_target,
  input  logic          zflag,
  output logic [AW-1:0] pc,
  output logic          exec_en,
  output logic          halted,
  output logic [CW-1:0] instr_count
);

  seq_state_e    state, state_nxt;
  logic [AW-1:0] pc_nxt, pc_inc;
  logic [CW-1:0] count_nxt;
  logic          step_rise;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    return v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  edge_detect u_step_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (step),
    .rise (step_rise)
  );

  assign pc_inc = pc + {{(AW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = instr_count;
    exec_en   = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt    = '0;
          count_nxt = '0;
          state_nxt = step_mode ? WAIT_STEP : RUN;
        end
      end
      WAIT_STEP: begin
        if (step_rise) state_nxt = STEP_EXEC;
      end
      RUN, STEP_EXEC: begin
        exec_en   = 1'b1;
        count_nxt = sat_inc(instr_count);
        // A single step always returns to waiting unless it retired a halt.
        if (state == STEP_EXEC) state_nxt = WAIT_STEP;
        case (br_op)
          BR_NEXT: pc_nxt = pc_inc;
          BR_JUMP: pc_nxt = br_target;
          BR_BZ:   pc_nxt = zflag ? br_target : pc_inc;
          default: state_nxt = HALT;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign halted = (state == HALT);

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer that drives the instruction-ROM address of the single-cycle ALU/register-file datapath, replacing the free-running address counter. Supports sequential fetch with wrap, unconditional jump, branch-if-zero on the ALU zero flag, halt, and single-step execution. It also gates the register-file write strobe, so the datapath only commits state in cycles where an instruction actually executes.

## Interface
Parameters:
- AW, 6, ROM address width
- CW, 16, width of executed-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- start  input  1  level; begins or restarts execution from address 0
- step_mode  input  1  sampled with start; 1 = single-step, 0 = free run
- step  input  1  level; each rising edge executes one instruction in step mode
- br_op  input  2  flow field of current instruction: 00 next, 01 jump, 10 branch-if-zero, 11 halt
- br_target  input  AW  jump/branch destination
- zflag  input  1  combinational ALU zero flag of the current instruction
- pc  output  AW  ROM address of the current instruction
- exec_en  output  1  current instruction executes; ANDed with the ROM write bit to form the register-file write strobe
- halted  output  1  sequencer is in HALT
- instr_count  output  CW  number of executed instructions since the last start

## Operation
- States: IDLE, RUN, WAIT_STEP, STEP_EXEC, HALT.
- Reset (rst low, asynchronous) forces state IDLE, pc=0, instr_count=0, and step edge register=0. Outputs during reset: exec_en=0, halted=0.
- exec_en=1 only in RUN and STEP_EXEC. halted=1 only in HALT.
- IDLE or HALT with start=1 clears pc and instr_count to 0. Next state is WAIT_STEP if step_mode=1, otherwise RUN.
- start is ignored in RUN, WAIT_STEP, and STEP_EXEC. step_mode is ignored except at start.
- In each executing cycle (RUN or STEP_EXEC), next pc is:
  - 00: pc+1, wrapping from 2^AW-1 to 0.
  - 01: br_target.
  - 10: br_target if zflag=1, else pc+1 (same wrap).
  - 11: pc held; next state HALT. The halt instruction itself executes, with exec_en=1.
- RUN with br_op != 11 stays in RUN.
- Step edge: step_rise = step & ~step_q, where step_q is step registered every cycle in all states.
- WAIT_STEP with step_rise goes to STEP_EXEC. pc is held while waiting.
- STEP_EXEC lasts exactly one cycle, then goes to WAIT_STEP, or to HALT if br_op=11.
- A step held high for multiple cycles executes exactly one instruction.
- instr_count increments on every executing cycle and saturates at 2^CW-1.
- Jump to the current pc (self-loop) is legal and runs forever in RUN.

## Timing
- pc is registered. The ROM and datapath are combinational, so br_op, br_target, and zflag for pc are valid in the same cycle.
- The next pc appears one cycle after the executing edge.
- start to first execution: start sampled high at edge N gives RUN with pc=0 after N; instruction 0 executes in cycle N+1.
- Step latency: step rising between edges N-1 and N gives STEP_EXEC after edge N+1. The instruction executes in that cycle, and pc updates at edge N+2.
- Halt: halt instruction executes in cycle K, HALT from edge K+1, and halted=1 from then on.
- Reset mid-run takes effect immediately; no partial write is possible because exec_en drops combinationally with the state.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, WAIT_STEP, STEP_EXEC, HALT);
  - br_op constants BR_NEXT=2'b00, BR_JUMP=2'b01, BR_BZ=2'b10, BR_HALT=2'b11.
- One sub-module, edge_detect: a registered rising-edge detector on step, with the same clk/rst.
- Next-pc mux and FSM live in prog_sequencer.

## Test plan
- Reset, then start=1 with step_mode=0 and all br_op=00 -> pc runs 0,1,…,63,0, exec_en=1 throughout, instr_count=64 after 64 cycles.
- pc=5 with br_op=10 and br_target=20: zflag=1 -> next pc=20; zflag=0 -> next pc=6.
- Halt at pc=3 -> halt instruction executes (exec_en=1), then halted=1, exec_en=0, pc stays 3, and instr_count=4. Start again -> pc=0 and instr_count=0.
- step_mode=1 at start, step held high 10 cycles -> exactly one instruction executes, pc 0→1; a second pulse gives pc=2.
- rst asserted low while in RUN at pc=40 -> pc=0, exec_en=0, and state IDLE immediately, without waiting for clk.
- CW=4, 20 executed instructions -> instr_count saturates at 15.
